// File: rtl/timer_cmp_tick.sv
// timer_cmp_tick: prescaler, 64-bit compare register and timer interrupt
// logic wrapped around an external machine-time counter.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset, wins over every other input
//   en_i           timer enable; low freezes ticks and clears the prescaler
//   prescale_i     divide ratio minus one, picked up at each prescaler wrap
//   tick_o         one-cycle increment strobe for the counter (from registers)
//   counter_val_i  current 64-bit counter value
//   cmp_wdata_i    write data for one 32-bit compare half
//   cmp_we_lo_i    write compare bits [31:0]
//   cmp_we_hi_i    write compare bits [63:32]
//   cmp_val_o      current compare register
//   split_o        high while a split (lo-then-hi) compare update is pending
//   irq_o          registered level timer interrupt
module timer_cmp_tick #(
  parameter int unsigned PrescalerWidth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [PrescalerWidth-1:0] prescale_i,
  output logic                      tick_o,
  input  logic [63:0]               counter_val_i,
  input  logic [31:0]               cmp_wdata_i,
  input  logic                      cmp_we_lo_i,
  input  logic                      cmp_we_hi_i,
  output logic [63:0]               cmp_val_o,
  output logic                      split_o,
  output logic                      irq_o
);

  localparam int unsigned CmpWidth  = 64;
  localparam int unsigned HalfWidth = 32;

  typedef enum logic {
    ARMED = 1'b0,
    SPLIT = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic                      en_q;
  logic [PrescalerWidth-1:0] pre_q, pre_d;
  logic [PrescalerWidth-1:0] ratio_q, ratio_d;
  logic [CmpWidth-1:0]       cmp_q, cmp_d;
  logic                      irq_q, irq_d;
  logic                      pre_wrap;

  // Tick is built only from registers so en_i has no combinational path out.
  assign pre_wrap = (pre_q == ratio_q);
  assign tick_o   = en_q & pre_wrap;

  // Prescaler: count up to the latched ratio, reload the ratio on wrap.
  always_comb begin
    pre_d   = pre_q;
    ratio_d = ratio_q;
    if (!en_i || pre_wrap) begin
      pre_d   = '0;
      ratio_d = prescale_i;
    end else begin
      pre_d = pre_q + PrescalerWidth'(1);
    end
  end

  // Compare value with this cycle's half writes already applied.
  always_comb begin
    cmp_d = cmp_q;
    if (cmp_we_lo_i) cmp_d[HalfWidth-1:0]        = cmp_wdata_i;
    if (cmp_we_hi_i) cmp_d[CmpWidth-1:HalfWidth] = cmp_wdata_i;
  end

  // Split-write tracking: a hi write always completes an update; a lo-only
  // write opens (or stays in) the half-updated window.
  always_comb begin
    state_d = state_q;
    if (cmp_we_hi_i) begin
      state_d = ARMED;
    end else if (cmp_we_lo_i) begin
      state_d = SPLIT;
    end
  end

  // Interrupt looks at the post-write compare and next state so it never
  // reflects a stale or half-written compare value.
  always_comb begin
    irq_d = (state_d == ARMED) && (counter_val_i >= cmp_d);
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARMED;
      en_q    <= 1'b0;
      pre_q   <= '0;
      ratio_q <= '0;
      cmp_q   <= '1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_i;
      pre_q   <= pre_d;
      ratio_q <= ratio_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
    end
  end

  assign cmp_val_o = cmp_q;
  assign split_o   = (state_q == SPLIT);
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_timer_cmp_tick.sv
// Self-checking bench for timer_cmp_tick: each step drives one cycle of
// stimulus and queues the outputs expected after the following clock edge.
module tb_timer_cmp_tick;

  localparam int unsigned PW = 16;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic [PW-1:0] prescale_i;
  logic          tick_o;
  logic [63:0]   counter_val_i;
  logic [31:0]   cmp_wdata_i;
  logic          cmp_we_lo_i;
  logic          cmp_we_hi_i;
  logic [63:0]   cmp_val_o;
  logic          split_o;
  logic          irq_o;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string         name;
    logic          rst;
    logic          en;
    logic [PW-1:0] pre;
    logic [63:0]   cnt;
    logic [31:0]   wd;
    logic          lo;
    logic          hi;
    logic          x_irq;
    logic          x_split;
    logic          x_tick;
    logic [63:0]   x_cmp;
  } step_t;

  step_t sb_q[$];

  timer_cmp_tick #(.PrescalerWidth(PW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .prescale_i    (prescale_i),
    .tick_o        (tick_o),
    .counter_val_i (counter_val_i),
    .cmp_wdata_i   (cmp_wdata_i),
    .cmp_we_lo_i   (cmp_we_lo_i),
    .cmp_we_hi_i   (cmp_we_hi_i),
    .cmp_val_o     (cmp_val_o),
    .split_o       (split_o),
    .irq_o         (irq_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic step_t mk(input string name, input logic rst, input logic en,
                               input logic [PW-1:0] pre, input logic [63:0] cnt,
                               input logic [31:0] wd, input logic lo, input logic hi,
                               input logic x_irq, input logic x_split, input logic x_tick,
                               input logic [63:0] x_cmp);
    step_t s;
    s.name = name; s.rst = rst; s.en = en; s.pre = pre; s.cnt = cnt;
    s.wd = wd; s.lo = lo; s.hi = hi;
    s.x_irq = x_irq; s.x_split = x_split; s.x_tick = x_tick; s.x_cmp = x_cmp;
    return s;
  endfunction

  // Drive one cycle away from the active edge and queue its expectation.
  task automatic apply(input step_t s);
    @(negedge clk_i);
    rst_i         = s.rst;
    en_i          = s.en;
    prescale_i    = s.pre;
    counter_val_i = s.cnt;
    cmp_wdata_i   = s.wd;
    cmp_we_lo_i   = s.lo;
    cmp_we_hi_i   = s.hi;
    sb_q.push_back(s);
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    step_t e;
    for (int i = 0; i < 2; i++) begin
      apply(mk($sformatf("reset_%0d", i), 1'b1, 1'b0, PW'(3), 64'd0, 32'd0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, ONES));
      e = sb_q.pop_front();
      tests_run++; if (irq_o !== e.x_irq) begin tests_failed++; $display("FAIL %s irq_o got %0b want %0b", e.name, irq_o, e.x_irq); end
      tests_run++; if (split_o !== e.x_split) begin tests_failed++; $display("FAIL %s split_o got %0b want %0b", e.name, split_o, e.x_split); end
      tests_run++; if (tick_o !== e.x_tick) begin tests_failed++; $display("FAIL %s tick_o got %0b want %0b", e.name, tick_o, e.x_tick); end
      tests_run++; if (cmp_val_o !== e.x_cmp) begin tests_failed++; $display("FAIL %s cmp_val_o got %h want %h", e.name, cmp_val_o, e.x_cmp); end
    end
  endtask

  // Ratio 3 out of reset: ticks on enabled cycles 4, 8, 12.
  task automatic test_prescaler();
    step_t e;
    for (int k = 1; k <= 13; k++) begin
      apply(mk($sformatf("tick_c%0d", k), 1'b0, 1'b1, PW'(3), 64'd0, 32'd0, 1'b0, 1'b0,
               1'b0, 1'b0, (k % 4) == 0, ONES));
      e = sb_q.pop_front();
      tests_run++; if (irq_o !== e.x_irq) begin tests_failed++; $display("FAIL %s irq_o got %0b want %0b", e.name, irq_o, e.x_irq); end
      tests_run++; if (split_o !== e.x_split) begin tests_failed++; $display("FAIL %s split_o got %0b want %0b", e.name, split_o, e.x_split); end
      tests_run++; if (tick_o !== e.x_tick) begin tests_failed++; $display("FAIL %s tick_o got %0b want %0b", e.name, tick_o, e.x_tick); end
      tests_run++; if (cmp_val_o !== e.x_cmp) begin tests_failed++; $display("FAIL %s cmp_val_o got %h want %h", e.name, cmp_val_o, e.x_cmp); end
    end
  endtask

  // Lo then hi write of 0x10 while the counter climbs from 9.
  task automatic test_cmp_split();
    step_t st[$];
    step_t e;
    st.push_back(mk("sp_dis", 1'b0, 1'b0, PW'(0), 64'h9, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ONES));
    st.push_back(mk("sp_lo", 1'b0, 1'b1, PW'(0), 64'h9, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_0000_0010));
    st.push_back(mk("sp_hi", 1'b0, 1'b1, PW'(0), 64'hA, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h10));
    for (int c = 'hB; c <= 'h12; c++)
      st.push_back(mk($sformatf("sp_cnt_%0h", c), 1'b0, 1'b1, PW'(0), 64'(c), 32'd0, 1'b0, 1'b0,
                      c >= 'h10, 1'b0, 1'b1, 64'h10));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb_q.pop_front();
      tests_run++; if (irq_o !== e.x_irq) begin tests_failed++; $display("FAIL %s irq_o got %0b want %0b", e.name, irq_o, e.x_irq); end
      tests_run++; if (split_o !== e.x_split) begin tests_failed++; $display("FAIL %s split_o got %0b want %0b", e.name, split_o, e.x_split); end
      tests_run++; if (tick_o !== e.x_tick) begin tests_failed++; $display("FAIL %s tick_o got %0b want %0b", e.name, tick_o, e.x_tick); end
      tests_run++; if (cmp_val_o !== e.x_cmp) begin tests_failed++; $display("FAIL %s cmp_val_o got %h want %h", e.name, cmp_val_o, e.x_cmp); end
    end
  endtask

  // Interrupt active, then a lo-only write drops it until re-armed and reached.
  task automatic test_lo_rewrite();
    step_t st[$];
    step_t e;
    st.push_back(mk("lr_hit", 1'b0, 1'b1, PW'(0), 64'h20, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h10));
    st.push_back(mk("lr_lo", 1'b0, 1'b1, PW'(0), 64'h20, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h100));
    st.push_back(mk("lr_hold0", 1'b0, 1'b1, PW'(0), 64'h20, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h100));
    st.push_back(mk("lr_hold1", 1'b0, 1'b1, PW'(0), 64'h200, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h100));
    st.push_back(mk("lr_hi", 1'b0, 1'b1, PW'(0), 64'h20, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h100));
    st.push_back(mk("lr_ff", 1'b0, 1'b1, PW'(0), 64'hFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h100));
    st.push_back(mk("lr_100", 1'b0, 1'b1, PW'(0), 64'h100, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h100));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb_q.pop_front();
      tests_run++; if (irq_o !== e.x_irq) begin tests_failed++; $display("FAIL %s irq_o got %0b want %0b", e.name, irq_o, e.x_irq); end
      tests_run++; if (split_o !== e.x_split) begin tests_failed++; $display("FAIL %s split_o got %0b want %0b", e.name, split_o, e.x_split); end
      tests_run++; if (tick_o !== e.x_tick) begin tests_failed++; $display("FAIL %s tick_o got %0b want %0b", e.name, tick_o, e.x_tick); end
      tests_run++; if (cmp_val_o !== e.x_cmp) begin tests_failed++; $display("FAIL %s cmp_val_o got %h want %h", e.name, cmp_val_o, e.x_cmp); end
    end
  endtask

  // Simultaneous write stays armed; then lo-only writes enter and stay in SPLIT.
  task automatic test_back_to_back();
    step_t st[$];
    step_t e;
    st.push_back(mk("bw_both", 1'b0, 1'b1, PW'(0), 64'h5, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0));
    st.push_back(mk("bw_lo", 1'b0, 1'b1, PW'(0), 64'h5, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h40));
    st.push_back(mk("bw_lo2", 1'b0, 1'b1, PW'(0), 64'h5, 32'h3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h3));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb_q.pop_front();
      tests_run++; if (irq_o !== e.x_irq) begin tests_failed++; $display("FAIL %s irq_o got %0b want %0b", e.name, irq_o, e.x_irq); end
      tests_run++; if (split_o !== e.x_split) begin tests_failed++; $display("FAIL %s split_o got %0b want %0b", e.name, split_o, e.x_split); end
      tests_run++; if (tick_o !== e.x_tick) begin tests_failed++; $display("FAIL %s tick_o got %0b want %0b", e.name, tick_o, e.x_tick); end
      tests_run++; if (cmp_val_o !== e.x_cmp) begin tests_failed++; $display("FAIL %s cmp_val_o got %h want %h", e.name, cmp_val_o, e.x_cmp); end
    end
  endtask

  // Reset during SPLIT (with a competing hi write) restores the reset state.
  task automatic test_reset_split();
    step_t st[$];
    step_t e;
    st.push_back(mk("rs_rst", 1'b1, 1'b1, PW'(0), 64'h5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ONES));
    st.push_back(mk("rs_run", 1'b0, 1'b1, PW'(0), 64'h5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ONES));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb_q.pop_front();
      tests_run++; if (irq_o !== e.x_irq) begin tests_failed++; $display("FAIL %s irq_o got %0b want %0b", e.name, irq_o, e.x_irq); end
      tests_run++; if (split_o !== e.x_split) begin tests_failed++; $display("FAIL %s split_o got %0b want %0b", e.name, split_o, e.x_split); end
      tests_run++; if (tick_o !== e.x_tick) begin tests_failed++; $display("FAIL %s tick_o got %0b want %0b", e.name, tick_o, e.x_tick); end
      tests_run++; if (cmp_val_o !== e.x_cmp) begin tests_failed++; $display("FAIL %s cmp_val_o got %h want %h", e.name, cmp_val_o, e.x_cmp); end
    end
  endtask

  // Compare near the top of the range, counter wraps to zero.
  task automatic test_wrap();
    step_t st[$];
    step_t e;
    st.push_back(mk("wr_lo", 1'b0, 1'b1, PW'(0), 64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0));
    st.push_back(mk("wr_hi", 1'b0, 1'b1, PW'(0), 64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0));
    st.push_back(mk("wr_max", 1'b0, 1'b1, PW'(0), ONES, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0));
    st.push_back(mk("wr_zero", 1'b0, 1'b1, PW'(0), 64'h0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0));
    st.push_back(mk("wr_one", 1'b0, 1'b1, PW'(0), 64'h1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb_q.pop_front();
      tests_run++; if (irq_o !== e.x_irq) begin tests_failed++; $display("FAIL %s irq_o got %0b want %0b", e.name, irq_o, e.x_irq); end
      tests_run++; if (split_o !== e.x_split) begin tests_failed++; $display("FAIL %s split_o got %0b want %0b", e.name, split_o, e.x_split); end
      tests_run++; if (tick_o !== e.x_tick) begin tests_failed++; $display("FAIL %s tick_o got %0b want %0b", e.name, tick_o, e.x_tick); end
      tests_run++; if (cmp_val_o !== e.x_cmp) begin tests_failed++; $display("FAIL %s cmp_val_o got %h want %h", e.name, cmp_val_o, e.x_cmp); end
    end
  endtask

  initial begin
    rst_i         = 1'b1;
    en_i          = 1'b0;
    prescale_i    = PW'(3);
    counter_val_i = 64'd0;
    cmp_wdata_i   = 32'd0;
    cmp_we_lo_i   = 1'b0;
    cmp_we_hi_i   = 1'b0;
    test_reset();
    test_prescaler();
    test_cmp_split();
    test_lo_rewrite();
    test_back_to_back();
    test_reset_split();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
